// File: rtl/frog_frame_renderer_pkg.sv
// Shared constants and types for the frog frame renderer.
// Grid geometry, lane layout, colours and play/win state.
package frog_frame_renderer_pkg;

  localparam int TILE_SHIFT = 5;
  localparam int GRID_COLS  = 20;
  localparam int GRID_ROWS  = 15;
  localparam int START_COL  = 9;
  localparam int START_ROW  = 14;
  localparam int WIN_FRAMES = 60;
  localparam int CNT_W      = 6;

  localparam int GOAL_ROW    = 0;
  localparam int WATER_FIRST = 1;
  localparam int WATER_LAST  = 6;
  localparam int MEDIAN_ROW  = 7;
  localparam int ROAD_FIRST  = 8;
  localparam int ROAD_LAST   = 13;
  localparam int START_LANE  = 14;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam rgb_t C_BLACK  = '{r: 3'd0, g: 3'd0, b: 3'd0};
  localparam rgb_t C_WHITE  = '{r: 3'd7, g: 3'd7, b: 3'd7};
  localparam rgb_t C_FROG   = '{r: 3'd7, g: 3'd7, b: 3'd0};
  localparam rgb_t C_GOAL   = '{r: 3'd0, g: 3'd7, b: 3'd0};
  localparam rgb_t C_WATER  = '{r: 3'd0, g: 3'd0, b: 3'd5};
  localparam rgb_t C_MEDIAN = '{r: 3'd3, g: 3'd3, b: 3'd3};
  localparam rgb_t C_ROAD   = '{r: 3'd1, g: 3'd1, b: 3'd1};

  typedef enum logic {
    PLAY = 1'b0,
    WIN  = 1'b1
  } state_t;

endpackage

// File: rtl/frog_move_ctrl.sv
// Frog movement: button edge capture, one prioritised move per
// frame, saturation at the grid border, and the win timer.
module frog_move_ctrl
  import frog_frame_renderer_pkg::*;
(
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Frame_Start,
  input  logic [3:0]       i_Btn,
  output logic [4:0]       o_Col,
  output logic [3:0]       o_Row,
  output logic             o_Win,
  output logic [CNT_W-1:0] o_Cnt
);

  state_t           r_State;
  logic [3:0]       r_Btn_Prev;
  logic [3:0]       r_Pend;
  logic [4:0]       r_Col;
  logic [3:0]       r_Row;
  logic [CNT_W-1:0] r_Cnt;
  logic [3:0]       w_Edge;
  logic [4:0]       w_Col;
  logic [3:0]       w_Row;

  assign w_Edge = i_Btn & ~r_Btn_Prev;

  // Next position from the highest-priority pending move (U>D>L>R).
  always_comb begin
    w_Col = r_Col;
    w_Row = r_Row;
    if (r_Pend[3]) begin
      if (r_Row != 4'd0) w_Row = r_Row - 4'd1;
    end else if (r_Pend[2]) begin
      if (r_Row != 4'(GRID_ROWS - 1)) w_Row = r_Row + 4'd1;
    end else if (r_Pend[1]) begin
      if (r_Col != 5'd0) w_Col = r_Col - 5'd1;
    end else if (r_Pend[0]) begin
      if (r_Col != 5'(GRID_COLS - 1)) w_Col = r_Col + 5'd1;
    end
  end

  // Play/win FSM, pending flags, position and win frame counter.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State    <= PLAY;
      r_Btn_Prev <= '0;
      r_Pend     <= '0;
      r_Col      <= 5'(START_COL);
      r_Row      <= 4'(START_ROW);
      r_Cnt      <= '0;
    end else begin
      r_Btn_Prev <= i_Btn;
      unique case (r_State)
        PLAY: begin
          if (i_Frame_Start) begin
            r_Col <= w_Col;
            r_Row <= w_Row;
            if (w_Row == 4'd0) begin
              r_State <= WIN;
              r_Pend  <= '0;
            end else begin
              r_Pend <= w_Edge;
            end
          end else begin
            r_Pend <= r_Pend | w_Edge;
          end
        end
        WIN: begin
          r_Pend <= '0;
          if (i_Frame_Start) begin
            if (r_Cnt == CNT_W'(WIN_FRAMES - 1)) begin
              r_State <= PLAY;
              r_Cnt   <= '0;
              r_Col   <= 5'(START_COL);
              r_Row   <= 4'(START_ROW);
            end else begin
              r_Cnt <= r_Cnt + 1'b1;
            end
          end
        end
        default: r_State <= PLAY;
      endcase
    end
  end

  assign o_Col = r_Col;
  assign o_Row = r_Row;
  assign o_Win = (r_State == WIN);
  assign o_Cnt = r_Cnt;

endmodule

// File: rtl/frog_frame_renderer.sv
// Frog game frame renderer: frame-start detect, move control and a
// two-stage tile colour pipeline with sync delayed to match.
module frog_frame_renderer
  import frog_frame_renderer_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic [9:0] i_Pixel_X,
  input  logic [9:0] i_Pixel_Y,
  input  logic       i_Display_Area,
  input  logic       i_Btn_Up,
  input  logic       i_Btn_Down,
  input  logic       i_Btn_Left,
  input  logic       i_Btn_Right,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [2:0] o_Red,
  output logic [2:0] o_Grn,
  output logic [2:0] o_Blu,
  output logic [4:0] o_Frog_Col,
  output logic [3:0] o_Frog_Row,
  output logic       o_Win
);

  logic             r_VSync_Q;
  logic             w_Frame_Start;
  logic [4:0]       w_Frog_Col;
  logic [3:0]       w_Frog_Row;
  logic             w_Win;
  logic [CNT_W-1:0] w_Cnt;
  logic [4:0]       w_Tile_Col;
  logic [4:0]       w_Tile_Row;
  logic             r_S1_HSync;
  logic             r_S1_VSync;
  logic             r_S1_De;
  logic             r_S1_Frog;
  logic [4:0]       r_S1_Row;
  logic             r_HSync;
  logic             r_VSync;
  rgb_t             r_Rgb;
  rgb_t             w_Rgb;

  frog_move_ctrl u_move (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Frame_Start (w_Frame_Start),
    .i_Btn         ({i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right}),
    .o_Col         (w_Frog_Col),
    .o_Row         (w_Frog_Row),
    .o_Win         (w_Win),
    .o_Cnt         (w_Cnt)
  );

  // Register vsync so its falling edge marks the start of a frame.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_VSync_Q <= 1'b1;
    else       r_VSync_Q <= i_VSync;
  end

  assign w_Frame_Start = r_VSync_Q & ~i_VSync;

  assign w_Tile_Col = 5'(i_Pixel_X >> TILE_SHIFT);
  assign w_Tile_Row = 5'(i_Pixel_Y >> TILE_SHIFT);

  // Stage 1: tile coordinates and frog-tile hit, sync carried along.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_S1_HSync <= 1'b1;
      r_S1_VSync <= 1'b1;
      r_S1_De    <= 1'b0;
      r_S1_Frog  <= 1'b0;
      r_S1_Row   <= '0;
    end else begin
      r_S1_HSync <= i_HSync;
      r_S1_VSync <= i_VSync;
      r_S1_De    <= i_Display_Area;
      r_S1_Frog  <= (w_Tile_Col == w_Frog_Col) &&
                    (w_Tile_Row == {1'b0, w_Frog_Row});
      r_S1_Row   <= w_Tile_Row;
    end
  end

  // Colour priority: blanking, win flash, frog, then lane by row.
  always_comb begin
    w_Rgb = C_BLACK;
    if (!r_S1_De) begin
      w_Rgb = C_BLACK;
    end else if (w_Win && w_Cnt[3]) begin
      w_Rgb = C_WHITE;
    end else if (r_S1_Frog) begin
      w_Rgb = C_FROG;
    end else if (r_S1_Row == 5'(GOAL_ROW)) begin
      w_Rgb = C_GOAL;
    end else if (r_S1_Row >= 5'(WATER_FIRST) &&
                 r_S1_Row <= 5'(WATER_LAST)) begin
      w_Rgb = C_WATER;
    end else if (r_S1_Row == 5'(MEDIAN_ROW) ||
                 r_S1_Row == 5'(START_LANE)) begin
      w_Rgb = C_MEDIAN;
    end else if (r_S1_Row >= 5'(ROAD_FIRST) &&
                 r_S1_Row <= 5'(ROAD_LAST)) begin
      w_Rgb = C_ROAD;
    end
  end

  // Stage 2: registered colour and sync to the DAC pins.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_HSync <= 1'b1;
      r_VSync <= 1'b1;
      r_Rgb   <= C_BLACK;
    end else begin
      r_HSync <= r_S1_HSync;
      r_VSync <= r_S1_VSync;
      r_Rgb   <= w_Rgb;
    end
  end

  assign o_HSync    = r_HSync;
  assign o_VSync    = r_VSync;
  assign o_Red      = r_Rgb.r;
  assign o_Grn      = r_Rgb.g;
  assign o_Blu      = r_Rgb.b;
  assign o_Frog_Col = w_Frog_Col;
  assign o_Frog_Row = w_Frog_Row;
  assign o_Win      = w_Win;

endmodule

// File: tb/tb_frog_frame_renderer.sv
// Bench for frog_frame_renderer: directed steps plus random frames
// checked against a behavioural game model.
module tb_frog_frame_renderer;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_HSync, i_VSync;
  logic [9:0] i_Pixel_X, i_Pixel_Y;
  logic       i_Display_Area;
  logic       i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right;
  logic       o_HSync, o_VSync;
  logic [2:0] o_Red, o_Grn, o_Blu;
  logic [4:0] o_Frog_Col;
  logic [3:0] o_Frog_Row;
  logic       o_Win;

  int ntests = 0;
  int nfail  = 0;

  int       m_col, m_row, m_cnt;
  bit       m_win;
  bit [3:0] m_pend;
  bit [3:0] prevb;

  frog_frame_renderer dut (
    .i_Clk          (i_Clk),
    .i_Rst          (i_Rst),
    .i_HSync        (i_HSync),
    .i_VSync        (i_VSync),
    .i_Pixel_X      (i_Pixel_X),
    .i_Pixel_Y      (i_Pixel_Y),
    .i_Display_Area (i_Display_Area),
    .i_Btn_Up       (i_Btn_Up),
    .i_Btn_Down     (i_Btn_Down),
    .i_Btn_Left     (i_Btn_Left),
    .i_Btn_Right    (i_Btn_Right),
    .o_HSync        (o_HSync),
    .o_VSync        (o_VSync),
    .o_Red          (o_Red),
    .o_Grn          (o_Grn),
    .o_Blu          (o_Blu),
    .o_Frog_Col     (o_Frog_Col),
    .o_Frog_Row     (o_Frog_Row),
    .o_Win          (o_Win)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge i_Clk);
    #1;
  endtask

  function automatic logic [8:0] exp_rgb(int x, int y, bit de);
    int tc;
    int tr;
    tc = x / 32;
    tr = y / 32;
    if (!de) return 9'o000;
    if (m_win && ((m_cnt / 8) % 2 == 1)) return 9'o777;
    if (tc == m_col && tr == m_row) return 9'o770;
    if (tr == 0) return 9'o070;
    if (tr <= 6) return 9'o005;
    if (tr == 7 || tr == 14) return 9'o333;
    return 9'o111;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_col"}, 32'(o_Frog_Col), m_col);
    chk({tag, "_row"}, 32'(o_Frog_Row), m_row);
    chk({tag, "_win"}, 32'(o_Win), 32'(m_win));
  endtask

  task automatic apply_frame(input bit [3:0] e);
    if (!m_win) begin
      if (m_pend[3])      m_row = (m_row > 0)  ? m_row - 1 : 0;
      else if (m_pend[2]) m_row = (m_row < 14) ? m_row + 1 : 14;
      else if (m_pend[1]) m_col = (m_col > 0)  ? m_col - 1 : 0;
      else if (m_pend[0]) m_col = (m_col < 19) ? m_col + 1 : 19;
      m_pend = e;
      if (m_row == 0) begin
        m_win  = 1'b1;
        m_cnt  = 0;
        m_pend = '0;
      end
    end else begin
      m_pend = '0;
      if (m_cnt == 59) begin
        m_win = 1'b0;
        m_cnt = 0;
        m_col = 9;
        m_row = 14;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cycle_btn(input bit [3:0] m, input bit fs);
    bit [3:0] e;
    e = m & ~prevb;
    prevb = m;
    {i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right} = m;
    i_VSync = !fs;
    cyc();
    if (fs) apply_frame(e);
    else if (!m_win) m_pend |= e;
    check_state(fs ? "fs" : "cyc");
  endtask

  task automatic do_frame(input bit [3:0] m, input bit [3:0] hold,
                          input bit [3:0] fsm);
    cycle_btn(m | hold, 1'b0);
    cycle_btn(hold, 1'b0);
    cycle_btn(hold | fsm, 1'b1);
    cycle_btn(hold, 1'b0);
  endtask

  task automatic check_pix(input int x, input int y, input bit de,
                           input string tag);
    i_VSync        = 1'b1;
    i_Pixel_X      = 10'(x);
    i_Pixel_Y      = 10'(y);
    i_Display_Area = de;
    cyc();
    cyc();
    chk(tag, 32'({o_Red, o_Grn, o_Blu}), 32'(exp_rgb(x, y, de)));
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    {i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right} = 4'b0;
    prevb  = '0;
    m_col  = 9;
    m_row  = 14;
    m_win  = 1'b0;
    m_cnt  = 0;
    m_pend = '0;
    cyc();
    i_Rst = 1'b0;
    check_state("rst");
  endtask

  initial begin
    i_Rst          = 1'b1;
    i_HSync        = 1'b1;
    i_VSync        = 1'b1;
    i_Pixel_X      = '0;
    i_Pixel_Y      = '0;
    i_Display_Area = 1'b0;
    {i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right} = 4'b0;
    prevb = '0;
    repeat (3) cyc();
    chk("rst_rgb", 32'({o_Red, o_Grn, o_Blu}), 32'd0);
    chk("rst_hs", 32'(o_HSync), 32'd1);
    chk("rst_vs", 32'(o_VSync), 32'd1);
    do_reset();

    // single Up move, then a quiet frame
    do_frame(4'b1000, 4'b0, 4'b0);
    chk("up_row", 32'(o_Frog_Row), 32'd13);
    do_frame(4'b0, 4'b0, 4'b0);

    // held Left over three frames moves once
    do_frame(4'b0010, 4'b0010, 4'b0);
    do_frame(4'b0, 4'b0010, 4'b0);
    do_frame(4'b0, 4'b0010, 4'b0);
    cycle_btn(4'b0, 1'b0);
    chk("hold_col", 32'(o_Frog_Col), 32'd8);

    // Up+Right together: Up wins, Right discarded
    do_frame(4'b1001, 4'b0, 4'b0);
    do_frame(4'b0, 4'b0, 4'b0);
    chk("prio_col", 32'(o_Frog_Col), 32'd8);
    chk("prio_row", 32'(o_Frog_Row), 32'd12);

    // edge on the frame-start cycle lands one frame later
    do_frame(4'b0, 4'b0, 4'b0001);
    chk("fsedge_a", 32'(o_Frog_Col), 32'd8);
    do_frame(4'b0, 4'b0, 4'b0);
    chk("fsedge_b", 32'(o_Frog_Col), 32'd9);

    // saturation at left edge and bottom row
    repeat (11) do_frame(4'b0010, 4'b0, 4'b0);
    chk("sat_col", 32'(o_Frog_Col), 32'd0);
    do_reset();
    do_frame(4'b0100, 4'b0, 4'b0);
    chk("sat_row", 32'(o_Frog_Row), 32'd14);

    // pixel colours and exact two-cycle latency
    check_pix(0, 0, 1'b0, "pix_blank");
    i_Pixel_X = 10'd288;
    i_Pixel_Y = 10'd448;
    i_Display_Area = 1'b1;
    cyc();
    chk("lat_1", 32'({o_Red, o_Grn, o_Blu}), 32'd0);
    cyc();
    chk("lat_2", 32'({o_Red, o_Grn, o_Blu}), 32'(9'o770));
    check_pix(0, 40, 1'b1, "pix_water");
    chk("pix_water_c", 32'({o_Red, o_Grn, o_Blu}), 32'(9'o005));
    check_pix(100, 230, 1'b1, "pix_median");
    check_pix(100, 300, 1'b1, "pix_road");
    check_pix(100, 10, 1'b1, "pix_goal");

    // hsync pulse delayed exactly two cycles
    i_HSync = 1'b0;
    cyc();
    i_HSync = 1'b1;
    chk("hs_d1", 32'(o_HSync), 32'd1);
    cyc();
    chk("hs_d2", 32'(o_HSync), 32'd0);
    cyc();
    chk("hs_d3", 32'(o_HSync), 32'd1);

    // asynchronous reset mid-line
    do_frame(4'b1000, 4'b0, 4'b0);
    i_HSync = 1'b0;
    i_Pixel_X = 10'd0;
    i_Pixel_Y = 10'd40;
    cyc();
    cyc();
    chk("pre_rst_hs", 32'(o_HSync), 32'd0);
    #2;
    i_Rst = 1'b1;
    #1;
    chk("arst_col", 32'(o_Frog_Col), 32'd9);
    chk("arst_row", 32'(o_Frog_Row), 32'd14);
    chk("arst_win", 32'(o_Win), 32'd0);
    chk("arst_rgb", 32'({o_Red, o_Grn, o_Blu}), 32'd0);
    chk("arst_hs", 32'(o_HSync), 32'd1);
    chk("arst_vs", 32'(o_VSync), 32'd1);
    i_HSync = 1'b1;
    do_reset();

    // win: fourteen Up frames, then sixty ignored frames
    repeat (13) do_frame(4'b1000, 4'b0, 4'b0);
    chk("win_13", 32'(o_Win), 32'd0);
    do_frame(4'b1000, 4'b0, 4'b0);
    chk("win_14", 32'(o_Win), 32'd1);
    for (int i = 0; i < 60; i++) begin
      do_frame(4'($urandom_range(1, 15)), 4'b0, 4'b0);
      check_pix($urandom_range(0, 639), $urandom_range(0, 479),
                1'b1, "win_pix");
    end
    chk("win_end", 32'(o_Win), 32'd0);
    chk("win_end_col", 32'(o_Frog_Col), 32'd9);
    chk("win_end_row", 32'(o_Frog_Row), 32'd14);

    // randomized frames against the model
    do_reset();
    for (int i = 0; i < 200; i++) begin
      bit [3:0] m;
      bit [3:0] f;
      int px;
      m = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
      if ($urandom_range(0, 3) == 0) m = 4'b1000;
      f = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      do_frame(m, 4'b0, f);
      px = ($urandom_range(0, 1) == 1) ?
           m_col * 32 + $urandom_range(0, 31) :
           $urandom_range(0, 639);
      check_pix(px, $urandom_range(0, 479),
                $urandom_range(0, 3) != 0, "rnd_pix");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/frog_frame_renderer.md
Name: frog_frame_renderer

Overview:
- Sits directly downstream of the VGA timing generator and consumes its hsync, vsync, pixel_x, pixel_y and display_area outputs.
- Holds the frog's grid position and the play/win state. Position updates at most once per frame, at frame start.
- Renders a tiled lane background plus the frog tile as 3-bit-per-channel RGB for the VGA DAC pins.
- Delays sync by the same pipeline depth as the colour path, so sync and colour leave aligned.

Parameters:
- TILE_SHIFT, 5: log2 of tile size in pixels (32x32 tiles).
- GRID_COLS, 20: tile columns (640/32).
- GRID_ROWS, 15: tile rows (480/32).
- START_COL, 9: frog column after reset or after a win.
- START_ROW, 14: frog row after reset or after a win.
- WIN_FRAMES, 60: number of frames the WIN state lasts.

Ports:
- i_Clk  input  1  pixel clock, the same clock as the timing generator.
- i_Rst  input  1  asynchronous reset, active-high.
- i_HSync  input  1  hsync from the timing generator (active-low).
- i_VSync  input  1  vsync from the timing generator (active-low).
- i_Pixel_X  input  10  current pixel column.
- i_Pixel_Y  input  10  current pixel row.
- i_Display_Area  input  1  high inside the 640x480 visible window.
- i_Btn_Up, i_Btn_Down, i_Btn_Left, i_Btn_Right  input  1 each  already debounced and synchronous to i_Clk, active-high.
- o_HSync  output  1  i_HSync delayed 2 cycles.
- o_VSync  output  1  i_VSync delayed 2 cycles.
- o_Red  output  3  red colour value.
- o_Grn  output  3  green colour value.
- o_Blu  output  3  blue colour value.
- o_Frog_Col  output  5  frog tile column.
- o_Frog_Row  output  4  frog tile row.
- o_Win  output  1  high while in the WIN state.

Behaviour:
- Reset (async, i_Rst=1):
  - o_Frog_Col=START_COL, o_Frog_Row=START_ROW.
  - State=PLAY, o_Win=0, frame counter=0, pending flags=0, button history=0.
  - RGB=0; o_HSync=1, o_VSync=1 (all pipeline sync stages reset to 1).
  - Reset mid-frame takes effect immediately; the outputs above hold until the first post-reset cycle.
- Frame start: the cycle in which registered i_VSync is 1 and current i_VSync is 0 (falling edge), producing a 1-cycle pulse.
- Button capture:
  - A rising edge on a button sets its pending flag.
  - A held button generates no further edges, so it yields exactly one move.
  - Multiple presses of the same button within one frame collapse to one move.
- Move application, at frame start in PLAY only:
  - Exactly one move is applied, chosen by priority Up > Down > Left > Right.
  - All pending flags clear on that frame start, including the losing directions.
  - Up: row-1, saturating at 0. Down: row+1, saturating at GRID_ROWS-1.
  - Left: col-1, saturating at 0. Right: col+1, saturating at GRID_COLS-1.
  - A saturated move still consumes its flag.
  - An edge coinciding with the frame-start cycle is captured for the next frame.
- State machine:
  - PLAY -> WIN when the updated row equals 0. The transition is registered at the same frame start; o_Win rises one cycle later.
  - WIN: buttons are ignored and pending flags are held at 0. The frame counter increments at each frame start.
  - WIN -> PLAY at the frame start where counter == WIN_FRAMES-1. On that transition: counter=0, position reset to START_COL/START_ROW, o_Win=0.
- Render pipeline (latency 2 cycles; hsync, vsync, display_area and pixel coords travel with the data):
  - Stage 1: tile_col = x >> TILE_SHIFT, tile_row = y >> TILE_SHIFT, compared against the frog position.
  - Stage 2: colour lookup, registered to the outputs.
- Colours, first match wins:
  - Not display_area: 0,0,0.
  - WIN and counter bit 3 = 1: 7,7,7.
  - Frog tile: 7,7,0.
  - Row 0 (goal): 0,7,0.
  - Rows 1-6 (water): 0,0,5.
  - Row 7 (median) and row 14 (start): 3,3,3.
  - Rows 8-13 (road): 1,1,1.
- The frog position is sampled by stage 1 directly, so a move lands mid-vblank and no frame is split.

Decomposition:
- Shared package holds:
  - Grid constants: TILE_SHIFT, GRID_COLS, GRID_ROWS, START_COL, START_ROW.
  - Lane row boundaries: goal row, water rows, median row, road rows, start row.
  - 3-bit RGB colour constants.
  - The 1-bit state encoding for PLAY/WIN.
- One natural sub-module, frog_move_ctrl: button edge capture, pending flags, priority move, saturation, win FSM and frame counter.
- The top level keeps frame-start detection and the render pipeline.

Test Plan:
- Reset check: assert i_Rst mid-line -> immediately o_Frog_Col=9, o_Frog_Row=14, o_Win=0, RGB=0, o_HSync=o_VSync=1.
- Single move: pulse i_Btn_Up for 1 cycle mid-frame -> row stays 14 until the vsync falling edge, is 13 one cycle after, and stays 13 through the following frame.
- Held button and priority: hold Left for 3 frames -> col 9->8 once. Press Up+Right in the same frame -> row-1 only, col unchanged, and Right is discarded.
- Saturation: from col 0 press Left -> col stays 0. From row 14 press Down -> row stays 14.
- Win sequence: 14 Up presses on successive frames -> o_Win=1 after the 14th frame start. Buttons are ignored for 60 frames, then o_Win=0 and the position returns to (9,14).
- Pixel alignment: drive x=288, y=448 with display_area=1 -> RGB=7,7,0 exactly 2 cycles later. Drive x=0, y=40 -> 0,0,5. A hsync low pulse appears on o_HSync delayed by exactly 2 cycles.
